// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: round-robin write-back arbiter with a per-register busy scoreboard
module regfile_wb_sched #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_valid_i,
  input  logic [5:0]           issue_rs1_i,
  input  logic [5:0]           issue_rs2_i,
  input  logic [6:0]           issue_rd_i,
  output logic                 issue_ready_o,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*6-1:0]    req_rd_i,
  input  logic [NREQ*DW-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic [6:0]           wb_rd_o,
  output logic [DW-1:0]        rddata_o,
  output logic [63:0]          busy_o
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, g, idx;
  logic [NREQ-1:0] gnt;
  logic found, haz, fire;
  logic [63:0] busy_q, busy_d;
  logic [6:0] wb_rd_q, wb_rd_d;
  logic [DW-1:0] rddata_q, rddata_d;
  // zero registers are never set busy, so their source checks come out clear
  assign haz = busy_q[issue_rs1_i] | busy_q[issue_rs2_i] | (issue_rd_i[6] & busy_q[issue_rd_i[5:0]]);
  assign fire = issue_valid_i & ~haz;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        g = idx;
      end
    end
    rr_ptr_d = found ? (g == PW'(NREQ - 1) ? '0 : g + 1'b1) : rr_ptr_q;
    wb_rd_d = {found, found ? req_rd_i[g*6 +: 6] : wb_rd_q[5:0]};
    rddata_d = found ? req_data_i[g*DW +: DW] : rddata_q;
  end
  // the clear lands on the same edge the register file captures the write
  always_comb begin
    busy_d = busy_q;
    if (wb_rd_q[6]) busy_d[wb_rd_q[5:0]] = 1'b0;
    if (fire && issue_rd_i[6] && issue_rd_i[4:0] != 5'd0) busy_d[issue_rd_i[5:0]] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      busy_q <= '0;
      wb_rd_q <= '0;
      rddata_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q <= busy_d;
      wb_rd_q <= wb_rd_d;
      rddata_q <= rddata_d;
    end
  end
  assign issue_ready_o = ~haz;
  assign req_ready_o = gnt;
  assign wb_rd_o = wb_rd_q;
  assign rddata_o = rddata_q;
  assign busy_o = busy_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed scenario tasks with hand-computed expectations
module tb_regfile_wb_sched;
  logic clk_i, rst_ni, issue_valid_i, issue_ready_o;
  logic [5:0] issue_rs1_i, issue_rs2_i;
  logic [6:0] issue_rd_i, wb_rd_o;
  logic [2:0] req_valid_i, req_ready_o;
  logic [17:0] req_rd_i;
  logic [95:0] req_data_i;
  logic [31:0] rddata_o;
  logic [63:0] busy_o;
  int checks, errors;

  regfile_wb_sched #(.NREQ(3), .DW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rd_i(issue_rd_i), .issue_ready_o(issue_ready_o),
    .req_valid_i(req_valid_i), .req_rd_i(req_rd_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .wb_rd_o(wb_rd_o), .rddata_o(rddata_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
    req_valid_i = 0; req_rd_i = 0; req_data_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1'($urandom); issue_rs1_i = 6'($urandom); issue_rs2_i = 6'($urandom);
      issue_rd_i = 7'($urandom); req_valid_i = 3'($urandom); req_rd_i = 18'($urandom);
      req_data_i = {$urandom, $urandom, $urandom};
      tick();
    end
    checks++; if (wb_rd_o !== 7'h00) begin errors++; $display("FAIL reset_wb_rd: got %h exp 00", wb_rd_o); end
    checks++; if (rddata_o !== 32'h0) begin errors++; $display("FAIL reset_rddata: got %h exp 0", rddata_o); end
    checks++; if (busy_o !== 64'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0", busy_o); end
    idle();
    rst_ni = 1;
    req_valid_i = 3'b111;
    #1;
    checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL reset_ptr: got %b exp 001", req_ready_o); end
    req_valid_i = 0;
    tick();
  endtask

  task automatic test_single();
    issue_valid_i = 1; issue_rd_i = 7'h45;
    #1;
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL single_issue_ready: got %b exp 1", issue_ready_o); end
    tick();
    issue_valid_i = 0; issue_rd_i = 0;
    checks++; if (busy_o !== 64'h20) begin errors++; $display("FAIL single_busy_set: got %h exp 20", busy_o); end
    req_valid_i = 3'b001; req_rd_i = 18'd5; req_data_i = 96'hDEADBEEF;
    #1;
    checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL single_grant: got %b exp 001", req_ready_o); end
    tick();
    req_valid_i = 0;
    checks++; if (wb_rd_o !== 7'h45) begin errors++; $display("FAIL single_wb_rd: got %h exp 45", wb_rd_o); end
    checks++; if (rddata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rddata: got %h exp deadbeef", rddata_o); end
    checks++; if (busy_o[5] !== 1'b1) begin errors++; $display("FAIL single_busy_during_wb: got %b exp 1", busy_o[5]); end
    tick();
    checks++; if (wb_rd_o !== 7'h05) begin errors++; $display("FAIL single_wb_idle: got %h exp 05", wb_rd_o); end
    checks++; if (rddata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rddata_hold: got %h exp deadbeef", rddata_o); end
    checks++; if (busy_o !== 64'h0) begin errors++; $display("FAIL single_busy_clear: got %h exp 0", busy_o); end
  endtask

  task automatic test_contention();
    // pointer is 1 after the single write; grant requester 2 to bring it back to 0
    req_valid_i = 3'b100; req_rd_i = {6'd2, 6'd0, 6'd0};
    #1;
    checks++; if (req_ready_o !== 3'b100) begin errors++; $display("FAIL cont_ptr1: got %b exp 100", req_ready_o); end
    tick();
    req_valid_i = 3'b111; req_rd_i = {6'd33, 6'd4, 6'd3};
    req_data_i = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    #1;
    checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL cont_g0: got %b exp 001", req_ready_o); end
    tick();
    checks++; if (wb_rd_o !== 7'h43 || rddata_o !== 32'hAAAA0000) begin errors++; $display("FAIL cont_wb0: got %h/%h exp 43/aaaa0000", wb_rd_o, rddata_o); end
    checks++; if (req_ready_o !== 3'b010) begin errors++; $display("FAIL cont_g1: got %b exp 010", req_ready_o); end
    tick();
    checks++; if (wb_rd_o !== 7'h44 || rddata_o !== 32'hBBBB0001) begin errors++; $display("FAIL cont_wb1: got %h/%h exp 44/bbbb0001", wb_rd_o, rddata_o); end
    checks++; if (req_ready_o !== 3'b100) begin errors++; $display("FAIL cont_g2: got %b exp 100", req_ready_o); end
    tick();
    checks++; if (wb_rd_o !== 7'h61 || rddata_o !== 32'hCCCC0002) begin errors++; $display("FAIL cont_wb2: got %h/%h exp 61/cccc0002", wb_rd_o, rddata_o); end
    req_valid_i = 3'b101;
    #1;
    checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL cont_101_first: got %b exp 001", req_ready_o); end
    tick();
    checks++; if (req_ready_o !== 3'b100) begin errors++; $display("FAIL cont_101_second: got %b exp 100", req_ready_o); end
    tick();
    req_valid_i = 0;
    checks++; if (wb_rd_o !== 7'h61 || rddata_o !== 32'hCCCC0002) begin errors++; $display("FAIL cont_wb_101: got %h/%h exp 61/cccc0002", wb_rd_o, rddata_o); end
    checks++; if (busy_o !== 64'h0) begin errors++; $display("FAIL cont_busy: got %h exp 0", busy_o); end
    tick();
  endtask

  task automatic test_raw();
    issue_valid_i = 1; issue_rd_i = 7'h47;
    tick();
    issue_valid_i = 0; issue_rd_i = 7'h00; issue_rs1_i = 6'd7;
    #1;
    checks++; if (busy_o !== 64'h80) begin errors++; $display("FAIL raw_busy: got %h exp 80", busy_o); end
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b exp 0", issue_ready_o); end
    issue_rs1_i = 6'd0;
    #1;
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL raw_rs1_zero: got %b exp 1", issue_ready_o); end
    issue_rs1_i = 6'd32;
    #1;
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL raw_rs1_32: got %b exp 1", issue_ready_o); end
    tick();
    // pointer is 0; requester 0 delivers reg 7, checked through rs2 this time
    issue_rs1_i = 6'd0; issue_rs2_i = 6'd7;
    req_valid_i = 3'b001; req_rd_i = 18'd7; req_data_i = 96'h1234;
    tick();
    req_valid_i = 0;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL raw_stall_wb_cycle: got %b exp 0", issue_ready_o); end
    checks++; if (wb_rd_o !== 7'h47) begin errors++; $display("FAIL raw_wb_rd: got %h exp 47", wb_rd_o); end
    tick();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL raw_release: got %b exp 1", issue_ready_o); end
    issue_rs2_i = 0;
    // zero registers are never marked busy
    issue_valid_i = 1; issue_rd_i = 7'h60;
    tick();
    issue_valid_i = 0; issue_rd_i = 0;
    checks++; if (busy_o !== 64'h0) begin errors++; $display("FAIL raw_zero_reg_busy: got %h exp 0", busy_o); end
  endtask

  task automatic test_waw();
    issue_valid_i = 1; issue_rd_i = 7'h68;
    #1;
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL waw_first: got %b exp 1", issue_ready_o); end
    tick();
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL waw_second_stall: got %b exp 0", issue_ready_o); end
    issue_rd_i = 7'h28;
    #1;
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL waw_nowrite: got %b exp 1", issue_ready_o); end
    issue_rd_i = 7'h68;
    tick();
    checks++; if (issue_ready_o !== 1'b0 || busy_o !== (64'h1 << 40)) begin errors++; $display("FAIL waw_hold: got %b/%h exp 0/%h", issue_ready_o, busy_o, 64'h1 << 40); end
    // pointer is 1 after the RAW write from requester 0
    req_valid_i = 3'b010; req_rd_i = {6'd0, 6'd40, 6'd0}; req_data_i = {32'h0, 32'h0F0F0F0F, 32'h0};
    #1;
    checks++; if (req_ready_o !== 3'b010) begin errors++; $display("FAIL waw_grant: got %b exp 010", req_ready_o); end
    tick();
    req_valid_i = 0;
    checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL waw_stall_wb_cycle: got %b exp 0", issue_ready_o); end
    checks++; if (wb_rd_o !== 7'h68 || rddata_o !== 32'h0F0F0F0F) begin errors++; $display("FAIL waw_wb: got %h/%h exp 68/0f0f0f0f", wb_rd_o, rddata_o); end
    tick();
    checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL waw_release: got %b exp 1", issue_ready_o); end
    issue_valid_i = 0; issue_rd_i = 0;
    tick();
    checks++; if (busy_o !== 64'h0) begin errors++; $display("FAIL waw_busy_clear: got %h exp 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    issue_valid_i = 1; issue_rd_i = 7'h49;
    tick();
    issue_valid_i = 0; issue_rd_i = 0;
    checks++; if (busy_o !== 64'h200) begin errors++; $display("FAIL mid_busy9: got %h exp 200", busy_o); end
    // pointer is 2 after the WAW write from requester 1
    req_valid_i = 3'b100; req_rd_i = {6'd9, 6'd0, 6'd0}; req_data_i = {32'h99999999, 64'h0};
    tick();
    req_valid_i = 0;
    checks++; if (wb_rd_o !== 7'h49) begin errors++; $display("FAIL mid_inflight: got %h exp 49", wb_rd_o); end
    #2 rst_ni = 0;
    #1;
    checks++; if (busy_o !== 64'h0 || wb_rd_o !== 7'h00 || rddata_o !== 32'h0) begin errors++; $display("FAIL mid_async_clear: got %h/%h/%h exp 0/00/0", busy_o, wb_rd_o, rddata_o); end
    tick();
    rst_ni = 1;
    req_valid_i = 3'b111; req_rd_i = {6'd12, 6'd11, 6'd10}; req_data_i = {32'h3, 32'h2, 32'h1};
    #1;
    checks++; if (req_ready_o !== 3'b001) begin errors++; $display("FAIL mid_ptr0: got %b exp 001", req_ready_o); end
    tick();
    req_valid_i = 0;
    checks++; if (wb_rd_o !== 7'h4A || rddata_o !== 32'h1) begin errors++; $display("FAIL mid_first_wb: got %h/%h exp 4a/1", wb_rd_o, rddata_o); end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    idle();
    test_reset();
    test_single();
    test_contention();
    test_raw();
    test_waw();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
